// File: rtl/mips_uart_pkg.sv
// Shared encodings for the mips memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package mips_uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TxdataOfs = 32'd0;
  localparam logic [31:0] StatusOfs = 32'd4;

  localparam int unsigned StFullBit  = 0;
  localparam int unsigned StEmptyBit = 1;
  localparam int unsigned StBusyBit  = 2;
  localparam int unsigned StOvfBit   = 3;
  localparam int unsigned StCountLsb = 4;
  localparam int unsigned StCountW   = 5;

endpackage

// File: rtl/mips_sync_fifo.sv
// Single-clock FIFO with occupancy count. Callers must not push when full
// or pop when empty; pointers wrap naturally since DEPTH is a power of two.
module mips_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible through count.
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mips_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a FIFO, a frame FSM
// drains it onto txd, STATUS reports FIFO/FSM state and a sticky overflow.
module mips_uart_tx
  import mips_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        tx_irq
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ovf_q, ovf_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            hit_data, hit_status, bit_end;
  logic [31:0]     status_word;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign hit_data   = (addr == BASE_ADDR + TxdataOfs);
  assign hit_status = (addr == BASE_ADDR + StatusOfs);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign fifo_push  = mem_we && hit_data && !fifo_full;

  mips_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .reset  (reset),
    .push_i (fifo_push),
    .wdata_i(wdata[7:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign bit_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    if (state_d == StStart)     txd_d = 1'b0;
    else if (state_d == StData) txd_d = shift_d[0];
  end

  always_comb begin
    ovf_d = ovf_q;
    if (mem_we && hit_status)                 ovf_d = 1'b0;
    else if (mem_we && hit_data && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    status_word                            = '0;
    status_word[StFullBit]                 = fifo_full;
    status_word[StEmptyBit]                = fifo_empty;
    status_word[StBusyBit]                 = (state_q != StIdle);
    status_word[StOvfBit]                  = ovf_q;
    status_word[StCountLsb +: StCountW]    = StCountW'(fifo_count);
  end

  assign rdata  = (mem_re && hit_status) ? status_word : 32'd0;
  assign txd    = txd_q;
  assign tx_irq = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_mips_uart_tx.sv
// Directed bench for mips_uart_tx with 4 clocks per bit and a 4-entry FIFO.
module tb_mips_uart_tx;

  localparam logic [31:0] Base   = 32'hFFFF0000;
  localparam logic [31:0] Status = 32'hFFFF0004;

  logic        CLK, reset, mem_we, mem_re, txd, tx_irq;
  logic [31:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;

  mips_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .BASE_ADDR   (32'hFFFF0000)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd),
    .tx_irq(tx_irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected per-cycle txd for one frame, cycle 0 at bit 0 of the array.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] v;
    logic        bv;
    for (int i = 0; i < 10; i++) begin
      bv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      v[4*i +: 4] = {4{bv}};
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1;
    addr   = a;
    wdata  = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic capture(input int n, output logic [119:0] v);
    v = '1;
    for (int i = 0; i < n; i++) begin
      v[i] = txd;
      tick();
      mem_we = 1'b0;
    end
  endtask

  task automatic read_status(output logic [31:0] r);
    mem_re = 1'b1;
    addr   = Status;
    #1;
    r      = rdata;
    mem_re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0; mem_we = 1'b0; mem_re = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL reset_irq got %b want 1", tx_irq); end
    read_status(r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL reset_status got %h want 00000002", r); end
    addr = Status; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_re got %h want 0", rdata); end
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    logic [119:0] v;
    wr(Base, 32'h0000_0055);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL latency_pre got %b want 1", txd); end
    checks++; if (tx_irq !== 1'b0) begin errors++; $display("FAIL irq_queued got %b want 0", tx_irq); end
    tick();
    capture(40, v);
    checks++;
    if (v[39:0] !== frame_bits(8'h55)) begin
      errors++; $display("FAIL frame_55 got %h want %h", v[39:0], frame_bits(8'h55));
    end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL post_frame_txd got %b want 1", txd); end
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL post_frame_irq got %b want 1", tx_irq); end
  endtask

  task automatic test_back_to_back();
    logic [119:0] v, e;
    mem_we = 1'b1; addr = Base; wdata = 32'h41;
    tick();
    wdata = 32'h42;
    tick();
    wdata = 32'h43;
    capture(120, v);
    e = {frame_bits(8'h43), frame_bits(8'h42), frame_bits(8'h41)};
    checks++; if (v !== e) begin errors++; $display("FAIL b2b_frames got %h want %h", v, e); end
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL b2b_idle_irq got %b want 1", tx_irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int n;
    mem_we = 1'b1; addr = Base;
    for (int i = 0; i < 6; i++) begin
      wdata = 32'h60 + i;
      tick();
    end
    mem_we = 1'b0;
    read_status(r);
    checks++; if (r !== 32'h4D) begin errors++; $display("FAIL ovf_status got %h want 0000004d", r); end
    wr(Status, 32'hFFFF_FFFF);
    read_status(r);
    checks++; if (r !== 32'h45) begin errors++; $display("FAIL ovf_clear got %h want 00000045", r); end
    n = 0;
    while (tx_irq !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++; if (n !== 195) begin errors++; $display("FAIL ovf_drain_cycles got %0d want 195", n); end
  endtask

  task automatic test_status_count();
    logic [31:0] r;
    mem_we = 1'b1; addr = Base;
    wdata = 32'h00; tick();
    wdata = 32'hA5; tick();
    wdata = 32'h5A; tick();
    mem_we = 1'b0;
    repeat (6) tick();
    read_status(r);
    checks++; if (r !== 32'h24) begin errors++; $display("FAIL data_status got %h want 00000024", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    int lows;
    repeat (10) tick();
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL bit3_txd got %b want 0", txd); end
    reset = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL async_txd got %b want 1", txd); end
    checks++; if (tx_irq !== 1'b1) begin errors++; $display("FAIL async_irq got %b want 1", tx_irq); end
    #2 reset = 1'b1;
    tick();
    read_status(r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h want 00000002", r); end
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL post_reset_quiet got %0d want 0", lows); end
  endtask

  task automatic test_decode();
    logic [31:0] r;
    int lows;
    mem_re = 1'b1;
    mem_we = 1'b1; addr = 32'hFFFF0008; wdata = 32'h77; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_ffff0008 got %h want 0", rdata); end
    tick();
    addr = 32'h0000_0000; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_00000000 got %h want 0", rdata); end
    tick();
    mem_we = 1'b0; addr = Base; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_txdata got %h want 0", rdata); end
    mem_re = 1'b0;
    read_status(r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL decode_status got %h want 00000002", r); end
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL decode_quiet got %0d want 0", lows); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_status_count();
    test_reset_mid_frame();
    test_decode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_uart_tx.md
Name: mips_uart_tx

Overview:
Memory-mapped UART transmitter on the mips core's data-memory bus. It sits downstream of the CPU and consumes the core's store traffic.
- Stores to TXDATA enqueue a byte into a FIFO.
- A frame FSM serialises each byte as 8N1 on txd.
- STATUS is readable so firmware can poll before writing.
- Gives the simulation a console output channel and gives hardware a debug port.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit (>=2)
FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..16)
BASE_ADDR, 32'hFFFF0000, TXDATA address; STATUS at BASE_ADDR+4

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_we  input  1  CPU store strobe, sampled on CLK rising edge
mem_re  input  1  CPU load strobe
addr  input  32  CPU data address
wdata  input  32  store data; only [7:0] used
rdata  output  32  load data, combinational
txd  output  1  serial output, idle high
tx_irq  output  1  high while FIFO empty and FSM idle

Behaviour:
Reset (reset=0, asynchronous):
- txd=1, FSM=IDLE, FIFO empty, baud counter=0, overflow flag=0, tx_irq=1.
- rdata follows the decode rules below (0 unless a STATUS read is selected).
- Reset mid-frame aborts the frame immediately: txd returns to 1 and queued bytes are lost.

Address decode:
- Exact 32-bit compare against BASE_ADDR and BASE_ADDR+4.
- All other addresses: no effect, rdata=0.

TXDATA write (mem_we=1, addr=BASE_ADDR):
- Pushes wdata[7:0] if the FIFO is not full at that edge.
- If full, the byte is dropped and overflow is set (sticky).
- A pop in the same cycle does not make room; fullness is evaluated before the pop.

STATUS write (addr=BASE_ADDR+4):
- Clears overflow; data is ignored.

STATUS read (mem_re=1, addr=BASE_ADDR+4), combinational rdata:
- [0] full
- [1] empty
- [2] busy (FSM != IDLE)
- [3] overflow
- [8:4] FIFO count
- [31:9] zero

TXDATA read: returns 0.

Simultaneous push and pop (not full): count unchanged, both take effect.

FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1; each state holds for one full bit time.
- IDLE: txd=1. If FIFO non-empty, pop into the shift register and go to START (txd=0 from that edge).
- START: after CLKS_PER_BIT cycles go to DATA with bit index 0.
- DATA: txd=shift[0], LSB first. Shift once per bit time. After bit 7 completes go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles.
  - At the end, if FIFO non-empty, pop and go directly to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.

Timing:
- Latency: write sampled at edge E into an empty idle block, txd falls at edge E+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- The FIFO count field saturates naturally at FIFO_DEPTH; FIFO pointers wrap modulo FIFO_DEPTH.

tx_irq = empty & (state==IDLE), combinational from registered state.

Decomposition:
Package mips_uart_pkg:
- state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
- register offsets (TXDATA_OFS=0, STATUS_OFS=4)
- STATUS bit positions

Sub-module mips_sync_fifo (parameters WIDTH, DEPTH):
- push/pop/full/empty/count, async active-low reset, same CLK/reset names.
- Instantiated once with WIDTH=8.

The top level holds address decode, STATUS mux, FSM and baud counter.

Test Plan:
All scenarios run with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset release, then write 0x55 to 0xFFFF0000 -> txd low 1 cycle after the write edge. Then 4-cycle bits 1,0,1,0,1,0,1,0, then stop 1. Frame totals 40 cycles. tx_irq returns to 1.
2. Write 0x41,0x42,0x43 on consecutive cycles -> three frames with no idle cycles between them (120 cycles of activity). Decoded bytes are 0x41,0x42,0x43.
3. Write 6 bytes back-to-back while idle:
   - The first is popped after 1 cycle; 4 fill the FIFO; the sixth is dropped.
   - STATUS read shows full=1 and overflow=1.
   - Write to 0xFFFF0004, then read: overflow=0.
4. STATUS read with FIFO holding 2 bytes during DATA -> rdata=0x00000024 (count=2, busy=1, empty=0, full=0).
5. Assert reset=0 mid-DATA bit 3 -> txd=1 immediately (asynchronous). STATUS after release = 0x00000002. No further frames appear.
6. Writes and reads to 0xFFFF0008 and 0x00000000 -> no FIFO change, rdata=0. A TXDATA read returns 0.
